// File: rtl/spi_frame_collector.sv
// Passive oversampling monitor for a PULPino SPI master bus (standard or quad mode).
// Splits each chip-select frame into cmd/addr/dummy/wdata/rdata and emits one packet.
module spi_frame_collector #(
  parameter int unsigned MAX_CMD_W   = 32,
  parameter int unsigned MAX_ADDR_W  = 32,
  parameter int unsigned MAX_DATA_W  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            spi_clk,
  input  logic                            spi_csn,
  input  logic [3:0]                      spi_sdo,
  input  logic [3:0]                      spi_sdi,
  input  logic                            cfg_quad,
  input  logic [5:0]                      cfg_cmd_len,
  input  logic [5:0]                      cfg_addr_len,
  input  logic [5:0]                      cfg_dummy_len,
  input  logic [$clog2(MAX_DATA_W+1)-1:0] cfg_wr_len,
  input  logic [$clog2(MAX_DATA_W+1)-1:0] cfg_rd_len,
  output logic                            pkt_valid,
  input  logic                            pkt_ready,
  output logic [MAX_CMD_W-1:0]            pkt_cmd,
  output logic [MAX_ADDR_W-1:0]           pkt_addr,
  output logic [MAX_DATA_W-1:0]           pkt_wdata,
  output logic [MAX_DATA_W-1:0]           pkt_rdata,
  output logic                            pkt_write,
  output logic                            pkt_read,
  output logic                            pkt_short,
  output logic                            pkt_long,
  output logic [15:0]                     pkt_bits,
  output logic                            err_cfg,
  output logic                            err_overflow,
  input  logic                            clr_err
);
  localparam int unsigned LenW = $clog2(MAX_DATA_W + 1);
  localparam int unsigned CntW = (LenW > 6) ? LenW : 6;

  typedef enum logic [3:0] {
    StWaitIdle, StIdle, StCmd, StAddr, StDummy, StWdata, StRdata, StTail, StEmit
  } state_e;
  // Phase lengths indexed 0..4 = cmd, addr, dummy, wdata, rdata.
  typedef logic [4:0][CntW-1:0] lens_t;

  function automatic logic [2:0] next_idx(input logic [2:0] from, input logic [4:0] nz);
    logic [2:0] idx;
    idx = 3'd5;
    for (int i = 4; i >= 0; i--) begin
      if (i >= int'(from) && nz[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic state_e phase_state(input logic [2:0] idx);
    case (idx)
      3'd0:    return StCmd;
      3'd1:    return StAddr;
      3'd2:    return StDummy;
      3'd3:    return StWdata;
      3'd4:    return StRdata;
      default: return StTail;
    endcase
  endfunction

  function automatic logic [CntW-1:0] len_of(input logic [2:0] idx, input lens_t lens);
    case (idx)
      3'd0:    return lens[0];
      3'd1:    return lens[1];
      3'd2:    return lens[2];
      3'd3:    return lens[3];
      3'd4:    return lens[4];
      default: return '0;
    endcase
  endfunction

  // Input synchronisers; index 0 is the newest sample.
  logic [SYNC_STAGES-1:0]      sclk_sync_q, csn_sync_q;
  logic [SYNC_STAGES-1:0][3:0] sdo_sync_q, sdi_sync_q;
  logic                        sclk_prev_q, csn_prev_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '0;
      sdo_sync_q  <= '0;
      sdi_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
      sdo_sync_q  <= {sdo_sync_q[SYNC_STAGES-2:0], spi_sdo};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      csn_prev_q  <= csn_sync_q[SYNC_STAGES-1];
    end
  end

  logic       sclk_s, csn_s, sclk_rise, csn_rise, csn_fall;
  logic [3:0] sdo_s, sdi_s;
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sdo_s     = sdo_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign csn_rise  = csn_s & ~csn_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;

  state_e                state_q, state_d;
  logic                  quad_q, quad_d;
  lens_t                 lens_q, lens_d, cfg_lens;
  logic [CntW-1:0]       rem_q, rem_d, step;
  logic [MAX_CMD_W-1:0]  cmd_q, cmd_d, pcmd_q, pcmd_d;
  logic [MAX_ADDR_W-1:0] addr_q, addr_d, paddr_q, paddr_d;
  logic [MAX_DATA_W-1:0] wdata_q, wdata_d, pwdata_q, pwdata_d;
  logic [MAX_DATA_W-1:0] rdata_q, rdata_d, prdata_q, prdata_d;
  logic [15:0]           bits_q, bits_d, pbits_q, pbits_d;
  logic                  short_q, short_d, long_q, long_d;
  logic                  pvalid_q, pvalid_d, pwrite_q, pwrite_d, pread_q, pread_d;
  logic                  pshort_q, pshort_d, plong_q, plong_d;
  logic                  err_cfg_q, err_cfg_d, err_ovf_q, err_ovf_d;
  logic                  cfg_set, ovf_set, cfg_bad;
  logic [4:0]            nz_q, nz_cfg;
  logic [2:0]            cur_idx, nxt;
  logic [16:0]           bits_sum;

  // Quad mode consumes whole nibbles, so lengths are truncated to a multiple of 4.
  always_comb begin
    cfg_lens[0] = CntW'(cfg_cmd_len);
    cfg_lens[1] = CntW'(cfg_addr_len);
    cfg_lens[2] = CntW'(cfg_dummy_len);
    cfg_lens[3] = CntW'(cfg_wr_len);
    cfg_lens[4] = CntW'(cfg_rd_len);
    cfg_bad     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cfg_bad = cfg_bad | (cfg_quad & (|cfg_lens[i][1:0]));
      if (cfg_quad) cfg_lens[i][1:0] = 2'b00;
      nz_cfg[i] = |cfg_lens[i];
      nz_q[i]   = |lens_q[i];
    end
  end

  always_comb begin
    case (state_q)
      StAddr:  cur_idx = 3'd1;
      StDummy: cur_idx = 3'd2;
      StWdata: cur_idx = 3'd3;
      StRdata: cur_idx = 3'd4;
      default: cur_idx = 3'd0;
    endcase
  end

  assign step = quad_q ? CntW'(4) : CntW'(1);

  always_comb begin
    state_d  = state_q;   quad_d   = quad_q;   lens_d  = lens_q;   rem_d    = rem_q;
    cmd_d    = cmd_q;     addr_d   = addr_q;   wdata_d = wdata_q;  rdata_d  = rdata_q;
    bits_d   = bits_q;    short_d  = short_q;  long_d  = long_q;
    pvalid_d = pvalid_q;  pcmd_d   = pcmd_q;   paddr_d = paddr_q;  pwdata_d = pwdata_q;
    prdata_d = prdata_q;  pwrite_d = pwrite_q; pread_d = pread_q;  pshort_d = pshort_q;
    plong_d  = plong_q;   pbits_d  = pbits_q;
    cfg_set  = 1'b0;      ovf_set  = 1'b0;     nxt     = 3'd0;     bits_sum = '0;

    if (pvalid_q && pkt_ready) pvalid_d = 1'b0;

    case (state_q)
      StWaitIdle: if (csn_s) state_d = StIdle;
      StIdle: begin
        if (csn_fall) begin
          quad_d  = cfg_quad;
          lens_d  = cfg_lens;
          cfg_set = cfg_bad;
          cmd_d   = '0;  addr_d  = '0;  wdata_d = '0;  rdata_d = '0;
          bits_d  = '0;  short_d = 1'b0; long_d = 1'b0;
          nxt     = next_idx(3'd0, nz_cfg);
          state_d = phase_state(nxt);
          rem_d   = len_of(nxt, cfg_lens);
        end
      end
      StCmd, StAddr, StDummy, StWdata, StRdata: begin
        if (csn_rise) begin
          short_d = 1'b1;
          state_d = StEmit;
        end else if (sclk_rise) begin
          case (state_q)
            StCmd:   cmd_d   = quad_q ? {cmd_q[MAX_CMD_W-5:0], sdo_s}
                                      : {cmd_q[MAX_CMD_W-2:0], sdo_s[0]};
            StAddr:  addr_d  = quad_q ? {addr_q[MAX_ADDR_W-5:0], sdo_s}
                                      : {addr_q[MAX_ADDR_W-2:0], sdo_s[0]};
            StWdata: wdata_d = quad_q ? {wdata_q[MAX_DATA_W-5:0], sdo_s}
                                      : {wdata_q[MAX_DATA_W-2:0], sdo_s[0]};
            StRdata: rdata_d = quad_q ? {rdata_q[MAX_DATA_W-5:0], sdi_s}
                                      : {rdata_q[MAX_DATA_W-2:0], sdi_s[1]};
            default: ;
          endcase
          bits_sum = {1'b0, bits_q} + (quad_q ? 17'd4 : 17'd1);
          bits_d   = bits_sum[16] ? 16'hFFFF : bits_sum[15:0];
          if (rem_q <= step) begin
            nxt     = next_idx(cur_idx + 3'd1, nz_q);
            state_d = phase_state(nxt);
            rem_d   = len_of(nxt, lens_q);
          end else begin
            rem_d = rem_q - step;
          end
        end
      end
      StTail: begin
        if (csn_rise) state_d = StEmit;
        else if (sclk_rise) long_d = 1'b1;
      end
      StEmit: begin
        // A packet consumed in this very cycle frees the slot for the new one.
        if (!pvalid_q || pkt_ready) begin
          pvalid_d = 1'b1;
          pcmd_d   = cmd_q;   paddr_d  = addr_q;  pwdata_d = wdata_q;  prdata_d = rdata_q;
          pwrite_d = nz_q[3]; pread_d  = nz_q[4]; pshort_d = short_q;  plong_d  = long_q;
          pbits_d  = bits_q;
        end else begin
          ovf_set = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StWaitIdle;
    endcase

    err_cfg_d = clr_err ? 1'b0 : (err_cfg_q | cfg_set);
    err_ovf_d = ovf_set ? 1'b1 : (clr_err ? 1'b0 : err_ovf_q);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StWaitIdle; quad_q   <= 1'b0; lens_q  <= '0;   rem_q    <= '0;
      cmd_q    <= '0;         addr_q   <= '0;   wdata_q <= '0;   rdata_q  <= '0;
      bits_q   <= '0;         short_q  <= 1'b0; long_q  <= 1'b0;
      pvalid_q <= 1'b0;       pcmd_q   <= '0;   paddr_q <= '0;   pwdata_q <= '0;
      prdata_q <= '0;         pwrite_q <= 1'b0; pread_q <= 1'b0; pshort_q <= 1'b0;
      plong_q  <= 1'b0;       pbits_q  <= '0;   err_cfg_q <= 1'b0; err_ovf_q <= 1'b0;
    end else begin
      state_q  <= state_d;    quad_q   <= quad_d;   lens_q  <= lens_d;  rem_q    <= rem_d;
      cmd_q    <= cmd_d;      addr_q   <= addr_d;   wdata_q <= wdata_d; rdata_q  <= rdata_d;
      bits_q   <= bits_d;     short_q  <= short_d;  long_q  <= long_d;
      pvalid_q <= pvalid_d;   pcmd_q   <= pcmd_d;   paddr_q <= paddr_d; pwdata_q <= pwdata_d;
      prdata_q <= prdata_d;   pwrite_q <= pwrite_d; pread_q <= pread_d; pshort_q <= pshort_d;
      plong_q  <= plong_d;    pbits_q  <= pbits_d;  err_cfg_q <= err_cfg_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign pkt_valid    = pvalid_q;
  assign pkt_cmd      = pcmd_q;
  assign pkt_addr     = paddr_q;
  assign pkt_wdata    = pwdata_q;
  assign pkt_rdata    = prdata_q;
  assign pkt_write    = pwrite_q;
  assign pkt_read     = pread_q;
  assign pkt_short    = pshort_q;
  assign pkt_long     = plong_q;
  assign pkt_bits     = pbits_q;
  assign err_cfg      = err_cfg_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_spi_frame_collector.sv
// Bench for spi_frame_collector: drives SPI frames at pin level and compares every cycle
// against a field-level model of the expected packets and sticky errors.
module tb_spi_frame_collector;
  localparam int S = 2;  // synchroniser depth
  localparam int H = 3;  // clk cycles per spi_clk half period

  logic        clk = 1'b0, rstn = 1'b0, spi_clk = 1'b0, spi_csn = 1'b1;
  logic [3:0]  spi_sdo = '0, spi_sdi = '0;
  logic        cfg_quad = 1'b0, pkt_ready = 1'b0, clr_err = 1'b0;
  logic [5:0]  cfg_cmd_len = '0, cfg_addr_len = '0, cfg_dummy_len = '0;
  logic [5:0]  cfg_wr_len = '0, cfg_rd_len = '0;
  logic        pkt_valid, pkt_write, pkt_read, pkt_short, pkt_long, err_cfg, err_overflow;
  logic [31:0] pkt_cmd, pkt_addr, pkt_wdata, pkt_rdata;
  logic [15:0] pkt_bits;

  spi_frame_collector dut (
    .clk(clk), .rstn(rstn), .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_sdo(spi_sdo),
    .spi_sdi(spi_sdi), .cfg_quad(cfg_quad), .cfg_cmd_len(cfg_cmd_len),
    .cfg_addr_len(cfg_addr_len), .cfg_dummy_len(cfg_dummy_len), .cfg_wr_len(cfg_wr_len),
    .cfg_rd_len(cfg_rd_len), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_cmd(pkt_cmd), .pkt_addr(pkt_addr), .pkt_wdata(pkt_wdata), .pkt_rdata(pkt_rdata),
    .pkt_write(pkt_write), .pkt_read(pkt_read), .pkt_short(pkt_short),
    .pkt_long(pkt_long), .pkt_bits(pkt_bits), .err_cfg(err_cfg),
    .err_overflow(err_overflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit quad; int lc; int la; int ld; int lw; int lr;
    logic [31:0] cmd; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;
    int edges;
  } frame_t;
  typedef struct {
    logic [31:0] cmd; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;
    logic wr; logic rd; logic sh; logic lg; logic [15:0] bits;
  } pkt_t;
  typedef struct { int at; pkt_t p; } emit_ev_t;
  typedef struct { int at; logic bad; } cfg_ev_t;

  int total = 0, bad = 0, cyc = 0;
  bit cmp_en = 0, rand_ready = 0;
  emit_ev_t emitq[$];
  cfg_ev_t  cfgq[$];
  int e_rd = 0, c_rd = 0;
  logic m_valid = 0, m_ecfg = 0, m_eovf = 0;
  pkt_t m_pkt = '{default: '0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int len_i(input frame_t f, input int i);
    int l;
    case (i)
      0: l = f.lc; 1: l = f.la; 2: l = f.ld; 3: l = f.lw; default: l = f.lr;
    endcase
    return f.quad ? (l & ~3) : l;
  endfunction

  function automatic logic [31:0] field_i(input frame_t f, input int i);
    case (i)
      0: return f.cmd; 1: return f.addr; 3: return f.wdata; 4: return f.rdata;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] msk(input logic [31:0] v, input int l);
    return (l >= 32) ? v : (v & ((32'd1 << l) - 32'd1));
  endfunction

  // Captured field = the top c bits of an L-bit field, where c is what the edges reached.
  function automatic pkt_t expect_of(input frame_t f);
    pkt_t p;
    int s, tot, got, st, c, l;
    logic [63:0] v;
    p = '{default: '0};
    s = f.quad ? 4 : 1;
    tot = 0;
    for (int i = 0; i < 5; i++) tot += len_i(f, i);
    got = f.edges * s;
    st = 0;
    for (int i = 0; i < 5; i++) begin
      l = len_i(f, i);
      c = got - st;
      if (c < 0) c = 0;
      if (c > l) c = l;
      v = (c == 0) ? 64'd0 : ({32'd0, field_i(f, i)} >> (l - c));
      case (i)
        0: p.cmd = v[31:0]; 1: p.addr = v[31:0]; 3: p.wdata = v[31:0]; 4: p.rdata = v[31:0];
        default: ;
      endcase
      st += l;
    end
    p.bits = 16'((got < tot) ? got : tot);
    p.sh = (got < tot);
    p.lg = (got > tot);
    p.wr = (len_i(f, 3) != 0);
    p.rd = (len_i(f, 4) != 0);
    return p;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rand_ready) pkt_ready = 1'($urandom);
  endtask

  task automatic drive_lanes(input frame_t f, input int k);
    int s, p, st, l, o;
    logic [63:0] fld;
    logic [3:0] ch;
    s = f.quad ? 4 : 1;
    p = k * s;
    spi_sdo = 4'($urandom);
    spi_sdi = 4'($urandom);
    st = 0;
    for (int i = 0; i < 5; i++) begin
      l = len_i(f, i);
      if (p >= st && p < st + l && i != 2) begin
        o = p - st;
        fld = {32'd0, field_i(f, i)};
        ch = 4'((fld >> (l - o - s)) & ((64'd1 << s) - 64'd1));
        if (i == 4) begin
          if (f.quad) spi_sdi = ch; else spi_sdi[1] = ch[0];
        end else begin
          if (f.quad) spi_sdo = ch; else spi_sdo[0] = ch[0];
        end
      end
      st += l;
    end
  endtask

  task automatic run_frame(input frame_t f, input bit push, input int rst_edge);
    cfg_ev_t ce;
    emit_ev_t ee;
    cfg_quad = f.quad;
    cfg_cmd_len = 6'(f.lc); cfg_addr_len = 6'(f.la); cfg_dummy_len = 6'(f.ld);
    cfg_wr_len = 6'(f.lw);  cfg_rd_len = 6'(f.lr);
    tick();
    spi_csn = 1'b0;
    ce.at = cyc + S + 1;
    ce.bad = f.quad && (((f.lc | f.la | f.ld | f.lw | f.lr) & 3) != 0);
    cfgq.push_back(ce);
    repeat (H) tick();
    for (int k = 0; k < f.edges; k++) begin
      drive_lanes(f, k);
      repeat (H) tick();
      spi_clk = 1'b1;
      if (k == rst_edge) begin
        rstn = 1'b0; tick(); tick(); rstn = 1'b1;
      end
      repeat (H) tick();
      spi_clk = 1'b0;
    end
    repeat (H) tick();
    spi_csn = 1'b1;
    if (push) begin
      ee.at = cyc + S + 2;
      ee.p = expect_of(f);
      emitq.push_back(ee);
    end
    repeat (10) tick();
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!pkt_valid && n < 60) begin tick(); n++; end
    chk(nm, 64'(pkt_valid), 64'd1);
  endtask

  task automatic consume();
    pkt_ready = 1'b1; tick(); pkt_ready = 1'b0; tick();
  endtask

  // Reference model: output register and sticky errors, advanced on each clk edge.
  always @(posedge clk) begin
    logic was_valid, cbad, ovf;
    cyc++;
    if (!rstn) begin
      m_valid = 0; m_pkt = '{default: '0}; m_ecfg = 0; m_eovf = 0;
      e_rd = emitq.size(); c_rd = cfgq.size();
    end else begin
      was_valid = m_valid; cbad = 0; ovf = 0;
      if (m_valid && pkt_ready) m_valid = 0;
      if (c_rd < cfgq.size() && cfgq[c_rd].at == cyc) begin cbad = cfgq[c_rd].bad; c_rd++; end
      if (e_rd < emitq.size() && emitq[e_rd].at == cyc) begin
        if (!was_valid || pkt_ready) begin m_pkt = emitq[e_rd].p; m_valid = 1; end
        else ovf = 1;
        e_rd++;
      end
      m_ecfg = clr_err ? 1'b0 : (m_ecfg | cbad);
      m_eovf = ovf ? 1'b1 : (clr_err ? 1'b0 : m_eovf);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid", 64'(pkt_valid), 64'(m_valid));
      chk("err_cfg", 64'(err_cfg), 64'(m_ecfg));
      chk("err_overflow", 64'(err_overflow), 64'(m_eovf));
      if (m_valid) begin
        chk("cmd", 64'(pkt_cmd), 64'(m_pkt.cmd));
        chk("addr", 64'(pkt_addr), 64'(m_pkt.addr));
        chk("wdata", 64'(pkt_wdata), 64'(m_pkt.wdata));
        chk("rdata", 64'(pkt_rdata), 64'(m_pkt.rdata));
        chk("write", 64'(pkt_write), 64'(m_pkt.wr));
        chk("read", 64'(pkt_read), 64'(m_pkt.rd));
        chk("short", 64'(pkt_short), 64'(m_pkt.sh));
        chk("long", 64'(pkt_long), 64'(m_pkt.lg));
        chk("bits", 64'(pkt_bits), 64'(m_pkt.bits));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    frame_t f1, f2, f3, fr;
    int s, tot;
    rstn = 1'b0;
    tick(); cmp_en = 1; tick();
    chk("rst_valid", 64'(pkt_valid), 64'd0);
    chk("rst_cmd", 64'(pkt_cmd), 64'd0);
    chk("rst_bits", 64'(pkt_bits), 64'd0);
    chk("rst_errs", 64'({err_cfg, err_overflow}), 64'd0);
    rstn = 1'b1;
    repeat (10) tick();

    f1 = '{quad: 0, lc: 8, la: 24, ld: 0, lw: 32, lr: 0, cmd: 32'h0B, addr: 32'h123456,
           wdata: 32'hDEADBEEF, rdata: 32'h0, edges: 64};
    run_frame(f1, 1, -1);
    wait_valid("std_valid");
    chk("std_cmd", 64'(pkt_cmd), 64'h0B);
    chk("std_addr", 64'(pkt_addr), 64'h123456);
    chk("std_wdata", 64'(pkt_wdata), 64'hDEADBEEF);
    chk("std_wr_rd", 64'({pkt_write, pkt_read}), 64'b10);
    chk("std_bits", 64'(pkt_bits), 64'd64);
    chk("std_short_long", 64'({pkt_short, pkt_long}), 64'b00);
    consume();

    f2 = '{quad: 1, lc: 8, la: 32, ld: 8, lw: 0, lr: 32, cmd: 32'h6B, addr: 32'hA5A50001,
           wdata: 32'h0, rdata: 32'hCAFEF00D, edges: 20};
    run_frame(f2, 1, -1);
    wait_valid("quad_valid");
    chk("quad_rdata", 64'(pkt_rdata), 64'hCAFEF00D);
    chk("quad_addr", 64'(pkt_addr), 64'hA5A50001);
    chk("quad_bits", 64'(pkt_bits), 64'd80);
    chk("quad_read", 64'(pkt_read), 64'd1);
    consume();

    f3 = f1; f3.edges = 44;
    run_frame(f3, 1, -1);
    wait_valid("short_valid");
    chk("short_flag", 64'(pkt_short), 64'd1);
    chk("short_bits", 64'(pkt_bits), 64'd44);
    chk("short_wdata", 64'(pkt_wdata), 64'hDEA);
    consume();

    f3 = f2; f3.edges = 22;
    run_frame(f3, 1, -1);
    wait_valid("long_valid");
    chk("long_flag", 64'(pkt_long), 64'd1);
    chk("long_rdata", 64'(pkt_rdata), 64'hCAFEF00D);
    consume();

    run_frame(f1, 1, -1);
    wait_valid("ovf_first");
    f3 = f1; f3.cmd = 32'h9F;
    run_frame(f3, 1, -1);
    chk("ovf_held_cmd", 64'(pkt_cmd), 64'h0B);
    chk("ovf_flag", 64'(err_overflow), 64'd1);
    clr_err = 1'b1; tick(); clr_err = 1'b0; tick();
    chk("ovf_cleared", 64'(err_overflow), 64'd0);
    consume();

    run_frame(f1, 0, 15);
    repeat (5) tick();
    chk("rst_frame_dropped", 64'(pkt_valid), 64'd0);
    run_frame(f2, 1, -1);
    wait_valid("after_rst_valid");
    chk("after_rst_rdata", 64'(pkt_rdata), 64'hCAFEF00D);
    consume();

    f3 = '{quad: 1, lc: 8, la: 10, ld: 0, lw: 8, lr: 0, cmd: 32'h6B, addr: 32'hC3,
           wdata: 32'h5A, rdata: 32'h0, edges: 6};
    run_frame(f3, 1, -1);
    wait_valid("cfg_valid");
    chk("cfg_err", 64'(err_cfg), 64'd1);
    chk("cfg_addr8", 64'(pkt_addr), 64'hC3);
    chk("cfg_bits", 64'(pkt_bits), 64'd24);
    consume();
    clr_err = 1'b1; tick(); clr_err = 1'b0; tick();
    chk("cfg_cleared", 64'(err_cfg), 64'd0);

    rand_ready = 1;
    for (int n = 0; n < 25; n++) begin
      fr.quad = 1'($urandom);
      fr.lc = $urandom_range(0, 32); fr.la = $urandom_range(0, 32);
      fr.ld = $urandom_range(0, 12); fr.lw = $urandom_range(0, 32);
      fr.lr = $urandom_range(0, 32);
      fr.cmd = msk($urandom, len_i(fr, 0));  fr.addr = msk($urandom, len_i(fr, 1));
      fr.wdata = msk($urandom, len_i(fr, 3)); fr.rdata = msk($urandom, len_i(fr, 4));
      s = fr.quad ? 4 : 1;
      tot = 0;
      for (int i = 0; i < 5; i++) tot += len_i(fr, i);
      fr.edges = tot / s;
      if ($urandom_range(0, 2) == 0) fr.edges = fr.edges + $urandom_range(0, 5) - 3;
      if (fr.edges < 0) fr.edges = 0;
      run_frame(fr, 1, -1);
      if (n % 5 == 4) begin clr_err = 1'b1; tick(); clr_err = 1'b0; end
    end
    rand_ready = 0;
    pkt_ready = 1'b1; repeat (5) tick(); pkt_ready = 1'b0; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
